// File: rtl/hex_line_tx_if.sv
// Bundle of the word-input and byte-output handshakes of hex_line_tx plus its status.
// Latency: none, wires only.
// Backpressure: word_ready / tx_ready are carried here; the interface adds no behaviour.
//
// Ports (master = producer/sink side, slave = hex_line_tx):
//   word_valid, word_data  -> word offered to the transmitter
//   word_ready             <- FIFO has room
//   tx_data, tx_valid      <- ASCII byte towards the console
//   tx_ready               -> console accepts the byte
//   busy, overflow_count   <- status
interface hex_line_tx_if #(
    parameter int WIDTH = 36
);
    logic             word_valid;
    logic [WIDTH-1:0] word_data;
    logic             word_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic [7:0]       overflow_count;

    modport master (
        output word_valid, word_data, tx_ready,
        input  word_ready, tx_data, tx_valid, busy, overflow_count
    );

    modport slave (
        input  word_valid, word_data, tx_ready,
        output word_ready, tx_data, tx_valid, busy, overflow_count
    );
endinterface

// File: rtl/hex_line_tx.sv
// Prints buffered words as ASCII hex lines (MSB nibble first, then optional CR and LF).
// Latency: word accepted in cycle 0 shows its first digit on tx_data in cycle 2.
// Backpressure: tx_ready=0 freezes the current byte; a full FIFO drops word_ready and counts ignored offers.
//
// Ports:
//   clock, reset   sole clock; asynchronous active-high reset
//   bus (slave)    word_valid/word_data/word_ready input handshake,
//                  tx_data/tx_valid/tx_ready byte output handshake,
//                  busy and saturating overflow_count status
module hex_line_tx #(
    parameter int WIDTH     = 36,
    parameter int DEPTH     = 4,   // power of 2, at least 2
    parameter int EOL_CRLF  = 1,
    parameter int LOWERCASE = 0
) (
    input logic           clock,
    input logic           reset,
    hex_line_tx_if.slave  bus
);
    localparam int NIB = (WIDTH + 3) / 4;
    localparam int SHW = NIB * 4;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIGITS = 2'd1;
    localparam logic [1:0] ST_CR     = 2'd2;
    localparam logic [1:0] ST_LF     = 2'd3;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [7:0]       ovf;
    logic [1:0]       state;
    logic [SHW-1:0]   sh;
    logic [CW-1:0]    cnt;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;

    logic             full;
    logic             push;
    logic             pop;
    logic [SHW-1:0]   popped;
    logic [SHW-1:0]   sh_shift;
    logic             xfer;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else if (LOWERCASE != 0)
            return 8'h57 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    assign full     = (count == (AW + 1)'(DEPTH));
    assign push     = bus.word_valid & ~full;
    // Only an idle FSM may take the head; it then owns the word in sh.
    assign pop      = (state == ST_IDLE) & (count != '0);
    // Zero-extend the stored word to a whole number of nibbles.
    assign popped   = SHW'(mem[rd_ptr]);
    assign sh_shift = sh << 4;
    assign xfer     = tx_valid_q & bus.tx_ready;

    assign bus.word_ready     = ~full;
    assign bus.tx_data        = tx_data_q;
    assign bus.tx_valid       = tx_valid_q;
    assign bus.busy           = (count != '0) | (state != ST_IDLE);
    assign bus.overflow_count = ovf;

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= bus.word_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ovf        <= '0;
            state      <= ST_IDLE;
            sh         <= '0;
            cnt        <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            // Simultaneous push and pop leave the occupancy unchanged.
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;

            if (bus.word_valid && full && (ovf != 8'hFF))
                ovf <= ovf + 8'd1;

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        sh         <= popped;
                        tx_data_q  <= hex_char(popped[SHW-1 -: 4]);
                        tx_valid_q <= 1'b1;
                        cnt        <= CW'(NIB - 1);
                        state      <= ST_DIGITS;
                    end
                end
                ST_DIGITS: begin
                    if (xfer) begin
                        if (cnt != '0) begin
                            sh        <= sh_shift;
                            tx_data_q <= hex_char(sh_shift[SHW-1 -: 4]);
                            cnt       <= cnt - 1'b1;
                        end else if (EOL_CRLF != 0) begin
                            tx_data_q <= 8'h0D;
                            state     <= ST_CR;
                        end else begin
                            tx_data_q <= 8'h0A;
                            state     <= ST_LF;
                        end
                    end
                end
                ST_CR: begin
                    if (xfer) begin
                        tx_data_q <= 8'h0A;
                        state     <= ST_LF;
                    end
                end
                default: begin
                    // LF: the line ends; IDLE spends one cycle before the next pop,
                    // which gives the single idle cycle between lines.
                    if (xfer) begin
                        tx_valid_q <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hex_line_tx.sv
module tb_hex_line_tx;
    logic clock;
    logic reset;

    hex_line_tx_if #(.WIDTH(36)) ia();
    hex_line_tx_if #(.WIDTH(14)) ib();

    hex_line_tx #(.WIDTH(36), .DEPTH(4), .EOL_CRLF(1), .LOWERCASE(0)) dut_a (
        .clock(clock), .reset(reset), .bus(ia)
    );
    hex_line_tx #(.WIDTH(14), .DEPTH(4), .EOL_CRLF(0), .LOWERCASE(1)) dut_b (
        .clock(clock), .reset(reset), .bus(ib)
    );

    int checks = 0;
    int failures = 0;
    int mode_a = 1;          // 0: tx_ready low, 1: high, 2: random
    int nbytes_a = 0;
    int nb_b = 0;
    int ovf_model = 0;
    int cyc = 0;
    byte exp_a[$];
    logic [7:0] log_b [10];
    int log_cyc [10];
    logic stall_a = 1'b0;
    logic [7:0] stall_dat = 8'h00;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: a line is the word's nibbles as text, MSB first, then CR LF.
    function automatic void model_a(input logic [35:0] w);
        for (int i = 8; i >= 0; i--) begin
            int n;
            n = int'((w >> (4 * i)) & 36'hF);
            if (n < 10) exp_a.push_back(byte'(48 + n));
            else        exp_a.push_back(byte'(65 + n - 10));
        end
        exp_a.push_back(8'h0D);
        exp_a.push_back(8'h0A);
    endfunction

    always @(posedge clock) begin
        #2;
        case (mode_a)
            0:       ia.tx_ready = 1'b0;
            1:       ia.tx_ready = 1'b1;
            default: ia.tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor / scoreboard for dut_a, plus acceptance-side expectation push.
    always @(negedge clock) begin
        if (reset) begin
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                checks++;
                if (!(ia.tx_valid === 1'b1 && ia.tx_data === stall_dat)) begin
                    failures++;
                    $display("FAIL stall_hold actual=%0b/%0h required=1/%0h", ia.tx_valid, ia.tx_data, stall_dat);
                end
            end
            if (ia.tx_valid && ia.tx_ready) begin
                nbytes_a++;
                checks++;
                if (exp_a.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte actual=%0h required=none", ia.tx_data);
                end else begin
                    byte e;
                    e = exp_a.pop_front();
                    if (ia.tx_data !== e) begin
                        failures++;
                        $display("FAIL byte_stream actual=%0h required=%0h", ia.tx_data, e);
                    end
                end
            end
            stall_a = ia.tx_valid && !ia.tx_ready;
            stall_dat = ia.tx_data;
            if (ia.word_valid && ia.word_ready)
                model_a(ia.word_data);
            if (ia.word_valid && !ia.word_ready && ovf_model < 255)
                ovf_model++;
        end
    end

    always @(negedge clock) begin
        if (!reset && ib.tx_valid && ib.tx_ready) begin
            if (nb_b < 10) begin
                log_b[nb_b] = ib.tx_data;
                log_cyc[nb_b] = cyc;
            end
            nb_b++;
        end
    end

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while ((ia.busy || exp_a.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 64'(n < budget), 64'd1);
    endtask

    task automatic send_word(input logic [35:0] w);
        int n;
        logic acc;
        n = 0;
        ia.word_valid = 1'b1;
        ia.word_data = w;
        do begin
            acc = ia.word_ready;
            tick();
            n++;
        end while (!acc && n < 500);
        ia.word_valid = 1'b0;
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [7:0] exp_b [10];
        int n0;
        int o0;
        int g;
        exp_b = '{8'h33, 8'h66, 8'h66, 8'h66, 8'h0A, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0A};

        reset = 1'b1;
        ia.word_valid = 1'b0;
        ia.word_data = '0;
        ib.word_valid = 1'b0;
        ib.word_data = '0;
        ib.tx_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_tx_valid", 64'(ia.tx_valid), 64'd0);
        chk("rst_tx_data", 64'(ia.tx_data), 64'd0);
        chk("rst_word_ready", 64'(ia.word_ready), 64'd1);
        chk("rst_busy", 64'(ia.busy), 64'd0);
        chk("rst_ovf", 64'(ia.overflow_count), 64'd0);
        reset = 1'b0;
        tick();

        // Single word, latency and line length.
        n0 = nbytes_a;
        ia.word_valid = 1'b1;
        ia.word_data = 36'h0_0000_ABCD;
        tick();
        ia.word_valid = 1'b0;
        chk("lat_cycle1_valid", 64'(ia.tx_valid), 64'd0);
        tick();
        chk("lat_cycle2_valid", 64'(ia.tx_valid), 64'd1);
        chk("lat_cycle2_data", 64'(ia.tx_data), 64'h30);
        wait_drain(100, "single_drain");
        chk("single_bytes", 64'(nbytes_a - n0), 64'd11);
        chk("single_idle", 64'(ia.tx_valid), 64'd0);

        // Overflow with the sink stalled.
        mode_a = 0;
        tick();
        n0 = nbytes_a;
        for (int i = 0; i < 6; i++) begin
            ia.word_valid = 1'b1;
            ia.word_data = 36'({$urandom(), $urandom()});
            tick();
        end
        ia.word_valid = 1'b0;
        chk("ovf_ready_low", 64'(ia.word_ready), 64'd0);
        chk("ovf_count", 64'(ia.overflow_count), 64'd1);
        mode_a = 1;
        wait_drain(200, "ovf_drain");
        chk("ovf_bytes", 64'(nbytes_a - n0), 64'd55);

        // Push and pop in the same IDLE cycle with three words queued.
        mode_a = 0;
        tick();
        o0 = int'(ia.overflow_count);
        for (int i = 0; i < 4; i++) begin
            ia.word_valid = 1'b1;
            ia.word_data = 36'({$urandom(), $urandom()});
            tick();
        end
        ia.word_valid = 1'b0;
        chk("pp_three_queued_ready", 64'(ia.word_ready), 64'd1);
        mode_a = 1;
        g = 0;
        do begin
            tick();
            g++;
        end while (ia.tx_valid && g < 50);
        chk("pp_reach_idle", 64'(g < 50), 64'd1);
        ia.word_valid = 1'b1;
        ia.word_data = 36'({$urandom(), $urandom()});
        chk("pp_ready_in_idle", 64'(ia.word_ready), 64'd1);
        tick();
        ia.word_valid = 1'b0;
        chk("pp_count_unchanged", 64'(ia.word_ready), 64'd1);
        chk("pp_ovf_unchanged", 64'(ia.overflow_count), 64'(o0));
        ia.word_valid = 1'b1;
        ia.word_data = 36'({$urandom(), $urandom()});
        tick();
        ia.word_valid = 1'b0;
        chk("pp_now_full", 64'(ia.word_ready), 64'd0);
        wait_drain(300, "pp_drain");

        // Random backpressure over 20 random words.
        mode_a = 2;
        for (int i = 0; i < 20; i++)
            send_word(36'({$urandom(), $urandom()}));
        wait_drain(3000, "bp_drain");
        chk("bp_ovf", 64'(ia.overflow_count), 64'(ovf_model));
        mode_a = 1;

        // Narrow, lowercase, LF-only variant.
        ib.word_valid = 1'b1;
        ib.word_data = 14'h3FFF;
        tick();
        ib.word_data = 14'h0000;
        tick();
        ib.word_valid = 1'b0;
        repeat (30) tick();
        chk("b_byte_count", 64'(nb_b), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < nb_b) chk($sformatf("b_byte%0d", i), 64'(log_b[i]), 64'(exp_b[i]));
        end
        if (nb_b >= 6) chk("b_idle_gap", 64'(log_cyc[5] - log_cyc[4]), 64'd2);

        // Reset mid-line with two words queued.
        mode_a = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            ia.word_valid = 1'b1;
            ia.word_data = 36'({$urandom(), $urandom()});
            tick();
        end
        ia.word_valid = 1'b0;
        mode_a = 1;
        n0 = nbytes_a;
        g = 0;
        while (nbytes_a < n0 + 3 && g < 50) begin
            tick();
            g++;
        end
        chk("mid_three_digits", 64'(nbytes_a - n0), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_tx_valid", 64'(ia.tx_valid), 64'd0);
        chk("mid_rst_word_ready", 64'(ia.word_ready), 64'd1);
        chk("mid_rst_busy", 64'(ia.busy), 64'd0);
        chk("mid_rst_ovf", 64'(ia.overflow_count), 64'd0);
        exp_a.delete();
        ovf_model = 0;
        tick();
        reset = 1'b0;
        n0 = nbytes_a;
        repeat (50) tick();
        chk("post_rst_silent", 64'(nbytes_a - n0), 64'd0);
        chk("post_rst_busy", 64'(ia.busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
